// File: rtl/gate_deadtime_interlock.sv
// Gate drive interlock: dead-time insertion, shoot-through block, max on-time watchdog, fault latch.
// Optional GDI_INPUT_SYNC_EN adds 2-flop synchronizers on K1, K2 and flt_n.
module gate_deadtime_interlock #(
  parameter int DT_CYC     = 20,
  parameter int MAX_ON_CYC = 5000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       K1,
  input  logic       K2,
  input  logic       flt_n,
  input  logic       clr_fault,
  output logic       g_hi,
  output logic       g_lo,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       dt_active,
  output logic [7:0] pulse_cnt
);

  typedef enum logic [2:0] {S_DEAD, S_OFF, S_HI, S_LO, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DT_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_ON  = CNT_W'(MAX_ON_CYC);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_SHOOT = 2'b01;
  localparam logic [1:0] CODE_MAXON = 2'b10;
  localparam logic [1:0] CODE_EXT   = 2'b11;

  logic k1_s, k2_s, flt_n_s;

`ifdef GDI_INPUT_SYNC_EN
  logic [1:0] k1_sync_q, k2_sync_q, flt_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      k1_sync_q  <= 2'b00;
      k2_sync_q  <= 2'b00;
      flt_sync_q <= 2'b11;
    end else begin
      k1_sync_q  <= {k1_sync_q[0], K1};
      k2_sync_q  <= {k2_sync_q[0], K2};
      flt_sync_q <= {flt_sync_q[0], flt_n};
    end
  end

  assign k1_s    = k1_sync_q[1];
  assign k2_s    = k2_sync_q[1];
  assign flt_n_s = flt_sync_q[1];
`else
  assign k1_s    = K1;
  assign k2_s    = K2;
  assign flt_n_s = flt_n;
`endif

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_pulse(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [7:0]       pulse_q, pulse_d;
  logic [1:0]       code_q, code_d;
  logic             g_hi_q, g_lo_q, fault_q, dt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    on_cnt_d = on_cnt_q;
    pulse_d  = pulse_q;
    code_d   = code_q;
    case (state_q)
      S_DEAD: begin
        if (!flt_n_s) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (cnt_q == DT_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (!flt_n_s) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (k1_s && k2_s) begin
          state_d = S_FAULT;
          code_d  = CODE_SHOOT;
        end else if (k1_s) begin
          state_d  = S_HI;
          on_cnt_d = CNT_W'(1);
        end else if (k2_s) begin
          state_d  = S_LO;
          on_cnt_d = CNT_W'(1);
        end
      end
      S_HI: begin
        if (!flt_n_s) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (k1_s && k2_s) begin
          state_d = S_FAULT;
          code_d  = CODE_SHOOT;
        end else if (MAX_ON_CYC != 0 && k1_s && on_cnt_q == MAX_ON) begin
          state_d = S_FAULT;
          code_d  = CODE_MAXON;
        end else if (!k1_s) begin
          state_d = S_DEAD;
          cnt_d   = '0;
          pulse_d = sat_inc_pulse(pulse_q);
        end else begin
          on_cnt_d = sat_inc_cnt(on_cnt_q);
        end
      end
      S_LO: begin
        if (!flt_n_s) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (k1_s && k2_s) begin
          state_d = S_FAULT;
          code_d  = CODE_SHOOT;
        end else if (MAX_ON_CYC != 0 && k2_s && on_cnt_q == MAX_ON) begin
          state_d = S_FAULT;
          code_d  = CODE_MAXON;
        end else if (!k2_s) begin
          state_d = S_DEAD;
          cnt_d   = '0;
          pulse_d = sat_inc_pulse(pulse_q);
        end else begin
          on_cnt_d = sat_inc_cnt(on_cnt_q);
        end
      end
      S_FAULT: begin
        // Leaving FAULT needs both commands idle so a stale command cannot re-fire a gate.
        if (clr_fault && !k1_s && !k2_s && flt_n_s) begin
          state_d = S_DEAD;
          cnt_d   = '0;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = S_DEAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DEAD;
      cnt_q    <= '0;
      on_cnt_q <= '0;
      pulse_q  <= '0;
      code_q   <= CODE_NONE;
      g_hi_q   <= 1'b0;
      g_lo_q   <= 1'b0;
      fault_q  <= 1'b0;
      dt_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      on_cnt_q <= on_cnt_d;
      pulse_q  <= pulse_d;
      code_q   <= code_d;
      g_hi_q   <= (state_d == S_HI);
      g_lo_q   <= (state_d == S_LO);
      fault_q  <= (state_d == S_FAULT);
      dt_q     <= (state_d == S_DEAD);
    end
  end

  assign g_hi       = g_hi_q;
  assign g_lo       = g_lo_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign dt_active  = dt_q;
  assign pulse_cnt  = pulse_q;

endmodule

// File: tb/tb_gate_deadtime_interlock.sv
// Scoreboard bench for gate_deadtime_interlock: each expected output change is queued with the
// number of cycles the previous output state must have lasted; a monitor pops on every change.
module tb_gate_deadtime_interlock;

  logic       clk = 1'b0;
  logic       rst, K1, K2, flt_n, clr_fault;
  logic       g_hi, g_lo, fault, dt_active;
  logic [1:0] fault_code;
  logic [7:0] pulse_cnt;

  gate_deadtime_interlock #(.DT_CYC(20), .MAX_ON_CYC(100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .K1(K1), .K2(K2), .flt_n(flt_n), .clr_fault(clr_fault),
    .g_hi(g_hi), .g_lo(g_lo), .fault(fault), .fault_code(fault_code),
    .dt_active(dt_active), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [13:0] snap;
    int          dur;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_change = 0;
  bit          mon_en = 1'b0;
  bit          first = 1'b1;
  logic [13:0] prev_snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Snapshot layout: {g_hi, g_lo, fault, fault_code[1:0], dt_active, pulse_cnt[7:0]}; dur 0 = unchecked.
  task automatic push(input string name, input bit gh, input bit gl, input bit f,
                      input logic [1:0] code, input bit dt, input int pc, input int dur);
    exp_t e;
    e.name = name;
    e.snap = {gh, gl, f, code, dt, 8'(pc)};
    e.dur  = dur;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [13:0] cur;
      exp_t        e;
      int          held;
      cur = {g_hi, g_lo, fault, fault_code, dt_active, pulse_cnt};
      checks++;
      if (g_hi === 1'b1 && g_lo === 1'b1) begin
        errors++;
        $display("FAIL overlap: g_hi=%b g_lo=%b at cycle %0d, required never both 1", g_hi, g_lo, cyc);
      end
      if (first || cur !== prev_snap) begin
        held = cyc - last_change;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.snap || (e.dur != 0 && held != e.dur)) begin
            errors++;
            $display("FAIL %s: got snap=%h after %0d cycles, required snap=%h after %0d cycles",
                     e.name, cur, held, e.snap, e.dur);
          end
        end
        prev_snap   = cur;
        last_change = cyc;
        first       = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; K1 = 1'b0; K2 = 1'b0; flt_n = 1'b1; clr_fault = 1'b0;
    push("reset", 0, 0, 0, 2'b00, 1, 0, 0);
    tick(1);
    mon_en = 1'b1;
    tick(2);
    rst = 1'b0;
    push("boot_off", 0, 0, 0, 2'b00, 0, 0, 22);
    tick(25);

    // Double pulse on K1; the low gap is the 21-cycle minimum the dead time allows.
    K1 = 1'b1; push("p1_on", 1, 0, 0, 2'b00, 0, 0, 6);
    tick(50);
    K1 = 1'b0; push("p1_dead", 0, 0, 0, 2'b00, 1, 1, 50); push("p1_off", 0, 0, 0, 2'b00, 0, 1, 20);
    tick(21);
    K1 = 1'b1; push("p2_on", 1, 0, 0, 2'b00, 0, 1, 1);
    tick(30);
    K1 = 1'b0; push("p2_dead", 0, 0, 0, 2'b00, 1, 2, 30); push("p2_off", 0, 0, 0, 2'b00, 0, 2, 20);
    tick(30);

    // Commutation high -> low on the same edge
    K1 = 1'b1; push("cm_hi", 1, 0, 0, 2'b00, 0, 2, 10);
    tick(40);
    K1 = 1'b0; K2 = 1'b1;
    push("cm_dead", 0, 0, 0, 2'b00, 1, 3, 40);
    push("cm_off", 0, 0, 0, 2'b00, 0, 3, 20);
    push("cm_lo", 0, 1, 0, 2'b00, 0, 3, 1);
    tick(30);
    K2 = 1'b0; push("cm_dead2", 0, 0, 0, 2'b00, 1, 4, 9); push("cm_off2", 0, 0, 0, 2'b00, 0, 4, 20);
    tick(30);

    // Shoot-through command, clear refused while K1 high
    K1 = 1'b1; K2 = 1'b1; push("st_fault", 0, 0, 1, 2'b01, 0, 4, 10);
    tick(1);
    K2 = 1'b0; clr_fault = 1'b1;
    tick(5);
    K1 = 1'b0; push("st_clear", 0, 0, 0, 2'b00, 1, 4, 6);
    tick(1);
    clr_fault = 1'b0; push("st_off", 0, 0, 0, 2'b00, 0, 4, 20);
    tick(25);

    // Max on-time watchdog
    K1 = 1'b1; push("mo_on", 1, 0, 0, 2'b00, 0, 4, 6); push("mo_fault", 0, 0, 1, 2'b10, 0, 4, 100);
    tick(300);
    K1 = 1'b0; clr_fault = 1'b1; push("mo_clear", 0, 0, 0, 2'b00, 1, 4, 200);
    tick(1);
    clr_fault = 1'b0; push("mo_off", 0, 0, 0, 2'b00, 0, 4, 20);
    tick(29);

    // External desaturation fault during LO
    K2 = 1'b1; push("ext_lo", 0, 1, 0, 2'b00, 0, 4, 10);
    tick(10);
    flt_n = 1'b0; push("ext_fault", 0, 0, 1, 2'b11, 0, 4, 10);
    tick(1);
    flt_n = 1'b1;
    tick(20);
    K2 = 1'b0;
    tick(5);
    clr_fault = 1'b1; push("ext_clear", 0, 0, 0, 2'b00, 1, 4, 26);
    tick(1);
    clr_fault = 1'b0; push("ext_off", 0, 0, 0, 2'b00, 0, 4, 20);
    tick(25);

    // Reset mid-pulse with K1 held high throughout
    K1 = 1'b1; push("rs_hi", 1, 0, 0, 2'b00, 0, 4, 6);
    tick(10);
    rst = 1'b1; push("rs_drop", 0, 0, 0, 2'b00, 1, 0, 10);
    tick(1);
    rst = 1'b0;
    push("rs_off", 0, 0, 0, 2'b00, 0, 0, 20);
    push("rs_reon", 1, 0, 0, 2'b00, 0, 0, 1);
    tick(39);
    K1 = 1'b0; push("rs_dead", 0, 0, 0, 2'b00, 1, 1, 19); push("rs_off2", 0, 0, 0, 2'b00, 0, 1, 20);
    tick(30);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected changes never seen (next %s), required 0", q.size(), q[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
